ingress_fifo_writer: RTL and testbench

//  Per-port ingress writer: takes a framed 6-bit beat stream from the line side, tags each beat with its
//  2-bit destination port, and writes 8-bit words {payload[5:0], dest[1:0]} into that port's input FIFO.
//  It feeds the scheduler, which reads these FIFOs. dest 2'b00 is never written; valid dest is 1..3.

---
 rtl/switch_pkg.sv | 23 ++
 rtl/ingress_stats.sv | 42 ++++
 rtl/ingress_fifo_writer.sv | 139 +++++++++++++
 tb/tb_ingress_fifo_writer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared switch types: port ids, ingress FSM states and the FIFO word packing.
// Used by the ingress writers and the scheduler that reads their FIFOs.
package switch_pkg;

    typedef logic [1:0] port_id_t;

    localparam port_id_t DEST_NONE = 2'b00;
    localparam port_id_t DEST_P1   = 2'b01;
    localparam port_id_t DEST_P2   = 2'b10;
    localparam port_id_t DEST_P3   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } ingress_state_t;

    // FIFO word layout seen by the scheduler: payload in the upper bits, destination tag low.
    function automatic logic [7:0] fifo_word(input logic [5:0] payload, input port_id_t dest);
        return {payload, dest};
    endfunction

endpackage

// File: rtl/ingress_stats.sv
// Frame statistics for one ingress port: forwarded, dropped and truncated frame counters.
// Each counter wraps modulo 2^CNT_W; one increment strobe per counter per cycle.
module ingress_stats #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frm_inc,
    input  logic             drop_inc,
    input  logic             trunc_inc,
    output logic [CNT_W-1:0] frm_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] trunc_cnt
);

    logic [CNT_W-1:0] frm_q, frm_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] trunc_q, trunc_d;

    always_comb begin
        frm_d   = frm_q + CNT_W'(frm_inc);
        drop_d  = drop_q + CNT_W'(drop_inc);
        trunc_d = trunc_q + CNT_W'(trunc_inc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frm_q   <= '0;
            drop_q  <= '0;
            trunc_q <= '0;
        end else begin
            frm_q   <= frm_d;
            drop_q  <= drop_d;
            trunc_q <= trunc_d;
        end
    end

    assign frm_cnt   = frm_q;
    assign drop_cnt  = drop_q;
    assign trunc_cnt = trunc_q;

endmodule

// File: rtl/ingress_fifo_writer.sv
// Ingress writer: tags line-side payload beats with their destination port and writes them to the FIFO.
// Statistics counters exist only when INGRESS_STATS_EN is defined; otherwise the count outputs are 0.
module ingress_fifo_writer
    import switch_pkg::*;
#(
    parameter port_id_t PORT_ID = 2'd1,
    parameter int       MAX_LEN = 16,
    parameter int       CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [5:0]       in_data,
    input  logic             fifo_afull,
    output logic             fifo_wrreq,
    output logic [7:0]       fifo_wrdata,
    output logic [CNT_W-1:0] frm_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] trunc_cnt,
    output ingress_state_t   state_dbg
);

    localparam int                LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);

    ingress_state_t   state_q, state_d;
    port_id_t         dest_q, dest_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             trunc_q, trunc_d;
    logic             wrreq_q, wrreq_d;
    logic [7:0]       wrdata_q, wrdata_d;
    logic             accept;
    logic             frm_inc, drop_inc, trunc_inc;

    // Beat handshake: a beat transfers on a cycle where in_valid && in_ready; in_ready never depends on in_valid.
    // Only FWD can stall (on fifo_afull) so the single in-flight registered write always has room.
    assign in_ready = !reset && ((state_q == FWD) ? !fifo_afull : 1'b1);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        len_d     = len_q;
        trunc_d   = trunc_q;
        wrreq_d   = 1'b0;
        wrdata_d  = wrdata_q;
        frm_inc   = 1'b0;
        drop_inc  = 1'b0;
        trunc_inc = 1'b0;
        if (accept) begin
            if (in_sop) begin
                // A header inside FWD closes the old frame as forwarded before the new one is judged.
                if (state_q == FWD) begin
                    frm_inc   = 1'b1;
                    trunc_inc = trunc_q;
                end
                if (in_data[1:0] == DEST_NONE || in_data[1:0] == PORT_ID) begin
                    drop_inc = 1'b1;
                    state_d  = in_eop ? IDLE : DROP;
                end else begin
                    dest_d  = in_data[1:0];
                    len_d   = '0;
                    trunc_d = 1'b0;
                    state_d = in_eop ? IDLE : FWD;
                end
            end else begin
                case (state_q)
                    FWD: begin
                        if (len_q < MAX_LEN_L) begin
                            wrreq_d  = 1'b1;
                            wrdata_d = fifo_word(in_data, dest_q);
                            len_d    = len_q + LEN_W'(1);
                        end else begin
                            trunc_d = 1'b1;
                        end
                        if (in_eop) begin
                            state_d   = IDLE;
                            frm_inc   = 1'b1;
                            trunc_inc = trunc_q || (len_q >= MAX_LEN_L);
                        end
                    end
                    DROP: begin
                        if (in_eop) begin
                            state_d = IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            dest_q   <= DEST_NONE;
            len_q    <= '0;
            trunc_q  <= 1'b0;
            wrreq_q  <= 1'b0;
            wrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            dest_q   <= dest_d;
            len_q    <= len_d;
            trunc_q  <= trunc_d;
            wrreq_q  <= wrreq_d;
            wrdata_q <= wrdata_d;
        end
    end

    assign fifo_wrreq  = wrreq_q;
    assign fifo_wrdata = wrdata_q;
    assign state_dbg   = state_q;

`ifdef INGRESS_STATS_EN
    ingress_stats #(
        .CNT_W(CNT_W)
    ) u_stats (
        .clk      (clk),
        .reset    (reset),
        .frm_inc  (frm_inc),
        .drop_inc (drop_inc),
        .trunc_inc(trunc_inc),
        .frm_cnt  (frm_cnt),
        .drop_cnt (drop_cnt),
        .trunc_cnt(trunc_cnt)
    );
`else
    logic unused_stats;
    assign unused_stats = ^{frm_inc, drop_inc, trunc_inc};
    assign frm_cnt      = '0;
    assign drop_cnt     = '0;
    assign trunc_cnt    = '0;
`endif

endmodule

// File: tb/tb_ingress_fifo_writer.sv
// Bench for ingress_fifo_writer (PORT_ID=1, MAX_LEN=4): directed frames, then random frames
// checked against a frame-level model; counter expectations follow INGRESS_STATS_EN.
module tb_ingress_fifo_writer;
  import switch_pkg::*;

  localparam int CNT_W = 16;
  localparam int MAX_LEN = 4;
  localparam logic [1:0] MY_PORT = 2'd1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic in_sop = 1'b0;
  logic in_eop = 1'b0;
  logic [5:0] in_data = '0;
  logic fifo_afull = 1'b0;
  logic fifo_wrreq;
  logic [7:0] fifo_wrdata;
  logic [CNT_W-1:0] frm_cnt, drop_cnt, trunc_cnt;
  ingress_state_t state_dbg;

  int n_vec = 0;
  int n_miss = 0;
  int m_frm = 0, m_drop = 0, m_trunc = 0;
  logic [7:0] exp_q[$];
  logic afull_rand_en = 1'b0;
  logic afull_at_edge = 1'b0;

  ingress_fifo_writer #(.PORT_ID(MY_PORT), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data), .fifo_afull(fifo_afull),
    .fifo_wrreq(fifo_wrreq), .fifo_wrdata(fifo_wrdata), .frm_cnt(frm_cnt),
    .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int v);
`ifdef INGRESS_STATS_EN
    logic [CNT_W-1:0] w;
    w = CNT_W'(v);
    return 32'(w);
`else
    return 32'(v - v);
`endif
  endfunction

  task automatic check_counters(input string tag);
    check_val({tag, "_frm"}, 32'(frm_cnt), exp_cnt(m_frm));
    check_val({tag, "_drop"}, 32'(drop_cnt), exp_cnt(m_drop));
    check_val({tag, "_trunc"}, 32'(trunc_cnt), exp_cnt(m_trunc));
  endtask

  // scoreboard / monitor
  always @(posedge clk) afull_at_edge = fifo_afull;

  initial begin
    forever begin
      @(negedge clk);
      if (fifo_wrreq) begin
        if (exp_q.size() == 0) check_val("unexpected_wr", {24'd0, fifo_wrdata}, 32'hFFFF_FFFF);
        else check_val("wrdata", {24'd0, fifo_wrdata}, {24'd0, exp_q.pop_front()});
      end
      if (afull_at_edge) check_val("wr_while_afull", {31'd0, fifo_wrreq}, 32'd0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (afull_rand_en) fifo_afull = ($urandom_range(0, 3) == 0);
    end
  end

  // drivers
  task automatic drive_beat(input logic sop, input logic eop, input logic [5:0] d);
    int budget;
    budget = 0;
    @(negedge clk);
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_data = d;
    #1;
    while (!in_ready && budget < 200) begin
      @(negedge clk); #1;
      budget++;
    end
    if (!in_ready) check_val("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  // Frame-level model: a forwarded frame yields its first MAX_LEN payloads tagged with dest.
  task automatic send_frame(input logic [1:0] dest, input int n, input logic no_eop, input logic gaps);
    logic [5:0] pl[$];
    for (int i = 0; i < n; i++) pl.push_back(6'($urandom_range(0, 63)));
    if (dest == 2'd0 || dest == MY_PORT) m_drop++;
    else begin
      m_frm++;
      if (n > MAX_LEN) m_trunc++;
      for (int i = 0; i < n && i < MAX_LEN; i++) exp_q.push_back({pl[i], dest});
    end
    drive_beat(1'b1, 1'b0, {4'($urandom_range(0, 15)), dest});
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      drive_beat(1'b0, (i == n - 1) && !no_eop, pl[i]);
    end
  endtask

  task automatic send_fixed3();
    m_frm++;
    exp_q.push_back(8'h16); exp_q.push_back(8'h2A); exp_q.push_back(8'hFE);
    drive_beat(1'b1, 1'b0, 6'b0000_10);
    drive_beat(1'b0, 1'b0, 6'h05);
    drive_beat(1'b0, 1'b0, 6'h0A);
    drive_beat(1'b0, 1'b1, 6'h3F);
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge clk);
    check_val(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int budget;
    #1;
    check_val("rst_ready", {31'd0, in_ready}, 32'd0);
    check_val("rst_wrreq", {31'd0, fifo_wrreq}, 32'd0);
    check_val("rst_wrdata", {24'd0, fifo_wrdata}, 32'd0);
    check_val("rst_state", {30'd0, state_dbg}, {30'd0, IDLE});
    check_counters("rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("idle_ready", {31'd0, in_ready}, 32'd1);

    // basic forward
    send_fixed3();
    drain("t1_drain");
    check_counters("t1");

    // own-port and null destination are dropped
    send_frame(2'd1, 4, 1'b0, 1'b0);
    send_frame(2'd0, 4, 1'b0, 1'b0);
    drain("t2_drain");
    check_counters("t2");

    // truncation at MAX_LEN
    send_frame(2'd2, 6, 1'b0, 1'b0);
    drain("t3_drain");
    check_counters("t3");

    // afull stall mid-frame
    fork
      send_frame(2'd3, 4, 1'b0, 1'b0);
      begin
        budget = 0;
        do begin @(negedge clk); budget++; end while (!fifo_wrreq && budget < 100);
        if (!fifo_wrreq) check_val("t4_wait_wr", {31'd0, fifo_wrreq}, 32'd1);
        repeat (5) begin
          @(negedge clk);
          fifo_afull = 1'b1;
          #1;
          check_val("t4_ready_low", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        fifo_afull = 1'b0;
      end
    join
    drain("t4_drain");
    check_counters("t4");

    // header without preceding eop retags subsequent words
    send_frame(2'd2, 3, 1'b1, 1'b0);
    send_frame(2'd3, 2, 1'b0, 1'b0);
    drain("t5_drain");
    check_counters("t5");

    // stray beats in IDLE are discarded
    drive_beat(1'b0, 1'b0, 6'h2B);
    drive_beat(1'b0, 1'b1, 6'h11);
    drain("stray_drain");
    check_counters("stray");

    // randomized frames with random backpressure
    afull_rand_en = 1'b1;
    for (int f = 0; f < 60; f++) begin
      logic [1:0] d;
      logic cut;
      d = 2'($urandom_range(0, 3));
      cut = (f < 59) && ($urandom_range(0, 5) == 0);
      send_frame(d, $urandom_range(1, 7), cut, 1'b1);
      if (!cut && $urandom_range(0, 4) == 0) drive_beat(1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
    end
    afull_rand_en = 1'b0;
    @(negedge clk);
    fifo_afull = 1'b0;
    drain("rand_drain");
    check_counters("rand");

    // async reset with a write pending
    send_frame(2'd3, 3, 1'b1, 1'b0);
    drive_beat(1'b0, 1'b0, 6'h15);
    #1;
    check_val("t6_pending", {31'd0, fifo_wrreq}, 32'd1);
    reset = 1'b1;
    #1;
    check_val("t6_wrreq", {31'd0, fifo_wrreq}, 32'd0);
    check_val("t6_state", {30'd0, state_dbg}, {30'd0, IDLE});
    check_val("t6_ready", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    m_frm = 0; m_drop = 0; m_trunc = 0;
    check_counters("t6");
    @(negedge clk);
    reset = 1'b0;
    send_frame(2'd2, 2, 1'b0, 1'b0);
    drain("post_rst_drain");
    check_counters("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
